stopwatch_ctrl: RTL

- Controller that sequences a chain of cascaded BCD decade-counter digits as a start/stop/lap/clear stopwatch.
- Divides the system clock into count ticks and increments the digit chain with ripple carry.
- Runs a 4-state mode FSM and provides a frozen split-time display path.
- Sits between the push-button command inputs and the 7-segment display driver.

---
 rtl/stopwatch_pkg.sv | 12 +
 rtl/bcd_digit.sv | 27 ++
 rtl/stopwatch_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch controller: mode states and BCD digit constants.
package stopwatch_pkg;
  localparam int         DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_SPLIT = 2'b11
  } state_t;
endpackage

// File: rtl/bcd_digit.sv
// One BCD decade digit: counts 0..9 when enabled, wraps 9->0 and flags carry to the next digit.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic               x,
  input  logic               reset,
  input  logic               clr,
  input  logic               en,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry
);

  logic [DIGIT_W-1:0] r_digit;

  always_ff @(posedge x or posedge reset) begin
    if (reset)
      r_digit <= '0;
    else if (clr)
      r_digit <= '0;
    else if (en)
      r_digit <= (r_digit == BCD_MAX) ? '0 : r_digit + DIGIT_W'(1);
  end

  assign digit = r_digit;
  assign carry = en && (r_digit == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/stop/lap/clear stopwatch: command edge detect, mode FSM, tick prescaler,
// cascaded BCD digit chain and a frozen split-time display path.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 10,
  parameter int DIGITS   = 4
) (
  input  logic                    x,
  input  logic                    reset,
  input  logic                    start_stop,
  input  logic                    lap,
  input  logic                    clear,
  output logic [DIGIT_W*DIGITS-1:0] count_bcd,
  output logic [DIGIT_W*DIGITS-1:0] disp_bcd,
  output logic                    running,
  output logic                    split,
  output logic                    overflow
);

  localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  state_t                       r_state, w_state_nxt;
  logic [2:0]                   r_cmd_q;
  logic                         r_armed;
  logic [PW-1:0]                r_presc;
  logic [DIGIT_W*DIGITS-1:0]    r_snap;
  logic                         r_ovf;
  logic [DIGIT_W*DIGITS-1:0]    w_count, w_count_nxt;
  logic [DIGITS-1:0]            w_en, w_carry;
  logic [2:0]                   w_rise;
  logic                         w_ev_clr, w_ev_ss, w_ev_lap;
  logic                         w_active, w_tick, w_clr, w_load_snap;

  // Events are masked for the first edge after reset so a level already held
  // high through reset is not mistaken for a fresh press.
  assign w_rise   = {clear, start_stop, lap} & ~r_cmd_q & {3{r_armed}};
  assign w_ev_clr = w_rise[2];
  assign w_ev_ss  = w_rise[1] & ~w_rise[2];
  assign w_ev_lap = w_rise[0] & ~|w_rise[2:1];

  always_ff @(posedge x or posedge reset) begin
    if (reset) begin
      r_cmd_q <= '0;
      r_armed <= 1'b0;
    end else begin
      r_cmd_q <= {clear, start_stop, lap};
      r_armed <= 1'b1;
    end
  end

  always_ff @(posedge x or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_load_snap = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ev_clr)     w_clr = 1'b1;
        else if (w_ev_ss) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_ev_ss) w_state_nxt = ST_PAUSE;
        else if (w_ev_lap) begin
          w_state_nxt = ST_SPLIT;
          w_load_snap = 1'b1;
        end
      end
      ST_SPLIT: begin
        if (w_ev_ss)       w_state_nxt = ST_PAUSE;
        else if (w_ev_lap) w_state_nxt = ST_RUN;
      end
      ST_PAUSE: begin
        if (w_ev_clr) begin
          w_state_nxt = ST_IDLE;
          w_clr       = 1'b1;
        end else if (w_ev_ss) w_state_nxt = ST_RUN;
      end
    endcase
  end

  assign w_active = (r_state == ST_RUN) || (r_state == ST_SPLIT);
  assign w_tick   = w_active && (r_presc == PRE_LAST);

  always_ff @(posedge x or posedge reset) begin
    if (reset)
      r_presc <= '0;
    else if ((r_state == ST_IDLE) || w_clr)
      r_presc <= '0;
    else if (w_active)
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [DIGIT_W-1:0] w_d;
    if (i == 0) begin : g_first
      assign w_en[i] = w_tick;
    end else begin : g_rest
      assign w_en[i] = w_carry[i-1];
    end
    bcd_digit u_digit (
      .x    (x),
      .reset(reset),
      .clr  (w_clr),
      .en   (w_en[i]),
      .digit(w_d),
      .carry(w_carry[i])
    );
    assign w_count[DIGIT_W*i +: DIGIT_W]     = w_d;
    // Post-edge digit value, so a snapshot taken on a tick edge includes that tick.
    assign w_count_nxt[DIGIT_W*i +: DIGIT_W] =
      w_en[i] ? ((w_d == BCD_MAX) ? '0 : w_d + DIGIT_W'(1)) : w_d;
  end

  always_ff @(posedge x or posedge reset) begin
    if (reset)                    r_ovf <= 1'b0;
    else if (w_clr)               r_ovf <= 1'b0;
    else if (w_carry[DIGITS-1])   r_ovf <= 1'b1;
  end

  always_ff @(posedge x or posedge reset) begin
    if (reset)            r_snap <= '0;
    else if (w_load_snap) r_snap <= w_count_nxt;
  end

  assign count_bcd = w_count;
  assign split     = (r_state == ST_SPLIT);
  assign disp_bcd  = split ? r_snap : w_count;
  assign running   = w_active;
  assign overflow  = r_ovf;

endmodule
